// File: rtl/mem_stage.sv
// Memory stage: non-memory instructions pass straight through to the writeback pipe;
// loads and stores run a bounded req/ack transaction with data memory.
module mem_stage #(
  parameter int N       = 32,
  parameter int M       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_M,
  input  logic         memw_M,
  input  logic         regmem_M,
  input  logic         regw_M,
  input  logic         pcload_M,
  input  logic [M-1:0] regScr_M,
  input  logic [N-1:0] ALUrslt_M,
  input  logic [N-1:0] wdata_M,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic         stall_M,
  output logic         pcload_o,
  output logic         regw_o,
  output logic         regmem_o,
  output logic [M-1:0] regScr_o,
  output logic [N-1:0] rslt_o,
  output logic         err_timeout,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   rdata_q;
  logic           aborted_q;
  logic           err_q;

  logic mem_op;
  logic is_load;

  // A store wins when both memw_M and regmem_M are set.
  assign mem_op  = valid_M & (memw_M | regmem_M);
  assign is_load = regmem_M & ~memw_M;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            state_q   <= WAIT;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            rdata_q   <= mem_rdata;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
            state_q   <= DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rdata_q   <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are forced to zero while reset is asserted, even for pass-through.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall_M   = 1'b0;
    pcload_o  = 1'b0;
    regw_o    = 1'b0;
    regmem_o  = 1'b0;
    regScr_o  = '0;
    rslt_o    = '0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            stall_M = 1'b1;
          end else if (valid_M) begin
            pcload_o = pcload_M;
            regw_o   = regw_M;
            regmem_o = regmem_M;
            regScr_o = regScr_M;
            rslt_o   = ALUrslt_M;
          end
        end
        WAIT: begin
          mem_req   = 1'b1;
          mem_we    = memw_M;
          mem_addr  = ALUrslt_M;
          mem_wdata = wdata_M;
          stall_M   = 1'b1;
        end
        DONE: begin
          pcload_o = pcload_M;
          regw_o   = regw_M & ~aborted_q;
          regmem_o = regmem_M & ~aborted_q;
          regScr_o = regScr_M;
          rslt_o   = is_load ? rdata_q : ALUrslt_M;
        end
        default: ;
      endcase
    end
  end

  assign err_timeout = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a per-instruction cycle model fills an expected queue that a
// negedge compare process checks, plus directed literal checks.
module tb_mem_stage;
  localparam int N       = 32;
  localparam int M       = 4;
  localparam int TIMEOUT = 16;

  logic         clk, rst;
  logic         valid_M, memw_M, regmem_M, regw_M, pcload_M;
  logic [M-1:0] regScr_M;
  logic [N-1:0] ALUrslt_M, wdata_M;
  logic         mem_req, mem_we;
  logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_ack;
  logic         stall_M, pcload_o, regw_o, regmem_o;
  logic [M-1:0] regScr_o;
  logic [N-1:0] rslt_o;
  logic         err_timeout;
  logic [1:0]   dbg_state;

  mem_stage #(.N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .valid_M(valid_M), .memw_M(memw_M), .regmem_M(regmem_M),
    .regw_M(regw_M), .pcload_M(pcload_M), .regScr_M(regScr_M), .ALUrslt_M(ALUrslt_M),
    .wdata_M(wdata_M), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_M(stall_M),
    .pcload_o(pcload_o), .regw_o(regw_o), .regmem_o(regmem_o), .regScr_o(regScr_o),
    .rslt_o(rslt_o), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic         valid, memw, regmem, regw, pcload;
    logic [M-1:0] scr;
    logic [N-1:0] alu, wd;
  } in_t;

  typedef struct packed {
    logic         stall, req, we;
    logic [N-1:0] addr, wdata;
    logic         pcload, regw, regmem;
    logic [M-1:0] scr;
    logic [N-1:0] rslt;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic err_m    = 1'b0;
  int   req_cnt  = 0;
  int   stall_cnt = 0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: one expected entry per driven cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall_M",     stall_M,     e.stall);
      chk("mem_req",     mem_req,     e.req);
      chk("mem_we",      mem_we,      e.we);
      chk("mem_addr",    mem_addr,    e.addr);
      chk("mem_wdata",   mem_wdata,   e.wdata);
      chk("pcload_o",    pcload_o,    e.pcload);
      chk("regw_o",      regw_o,      e.regw);
      chk("regmem_o",    regmem_o,    e.regmem);
      chk("regScr_o",    regScr_o,    e.scr);
      chk("rslt_o",      rslt_o,      e.rslt);
      chk("err_timeout", err_timeout, e.err);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      req_cnt   <= req_cnt + int'(mem_req);
      stall_cnt <= stall_cnt + int'(stall_M);
    end
  end

  // Driver tasks
  task automatic step(input in_t i, input logic ack, input logic [N-1:0] rd, input exp_t e);
    @(posedge clk);
    #1;
    valid_M = i.valid; memw_M = i.memw; regmem_M = i.regmem; regw_M = i.regw;
    pcload_M = i.pcload; regScr_M = i.scr; ALUrslt_M = i.alu; wdata_M = i.wd;
    mem_ack = ack; mem_rdata = rd;
    exp_q.push_back(e);
  endtask

  function automatic logic spur();
    return ($urandom_range(0, 3) == 0);
  endfunction

  // lat = WAIT cycle (1-based) carrying the ack; 0 or > TIMEOUT means no ack
  task automatic run_instr(input in_t i, input int lat, input logic [N-1:0] rd);
    exp_t e;
    logic acked;
    int   nwait;
    if (!(i.valid & (i.memw | i.regmem))) begin
      e = '0;
      if (i.valid) begin
        e.pcload = i.pcload; e.regw = i.regw; e.regmem = i.regmem;
        e.scr = i.scr; e.rslt = i.alu;
      end
      e.err = err_m;
      step(i, spur(), $urandom, e);
    end else begin
      e = '0; e.stall = 1'b1; e.err = err_m;
      step(i, spur(), $urandom, e);
      acked = (lat >= 1) && (lat <= TIMEOUT);
      nwait = acked ? lat : TIMEOUT;
      for (int k = 1; k <= nwait; k++) begin
        e = '0; e.stall = 1'b1; e.req = 1'b1; e.we = i.memw;
        e.addr = i.alu; e.wdata = i.wd; e.err = err_m;
        if (acked && k == lat) step(i, 1'b1, rd, e);
        else                   step(i, 1'b0, $urandom, e);
      end
      if (!acked) err_m = 1'b1;
      e = '0;
      e.pcload = i.pcload;
      e.regw   = acked & i.regw;
      e.regmem = acked & i.regmem;
      e.scr    = i.scr;
      e.rslt   = (i.regmem & ~i.memw) ? (acked ? rd : '0) : i.alu;
      e.err    = err_m;
      step(i, spur(), $urandom, e);
    end
  endtask

  function automatic in_t mk(input logic v, input logic w, input logic r, input logic rw,
                             input logic [M-1:0] s, input logic [N-1:0] a, input logic [N-1:0] d);
    in_t i;
    i.valid = v; i.memw = w; i.regmem = r; i.regw = rw; i.pcload = 1'b0;
    i.scr = s; i.alu = a; i.wd = d;
    return i;
  endfunction

  initial begin
    in_t i;
    exp_t e;
    int  lat;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    valid_M = 1'b1; memw_M = 1'b0; regmem_M = 1'b0; regw_M = 1'b1; pcload_M = 1'b1;
    regScr_M = 4'd5; ALUrslt_M = 32'hAA; wdata_M = 32'h0;
    #2;
    chk("reset stall_M", stall_M, 0);
    chk("reset mem_req", mem_req, 0);
    chk("reset regw_o", regw_o, 0);
    chk("reset rslt_o", rslt_o, 0);
    chk("reset err", err_timeout, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Non-memory op passes through in the same cycle
    req_cnt = 0; stall_cnt = 0;
    run_instr(mk(1, 0, 0, 1, 4'd3, 32'h0000_00AA, 32'h0), 0, '0);
    @(negedge clk);
    chk("nonmem regw_o", regw_o, 1);
    chk("nonmem regScr_o", regScr_o, 3);
    chk("nonmem rslt_o", rslt_o, 32'hAA);
    chk("nonmem stall", stall_M, 0);
    chk("nonmem req cycles", req_cnt, 0);

    // Load, ack on third WAIT cycle
    req_cnt = 0; stall_cnt = 0;
    run_instr(mk(1, 0, 1, 1, 4'd7, 32'h100, 32'h0), 3, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("load rslt_o", rslt_o, 32'hDEAD_BEEF);
    chk("load regmem_o", regmem_o, 1);
    chk("load stall cycles", stall_cnt, 4);
    chk("load req cycles", req_cnt, 3);

    // Store, ack in first WAIT cycle
    req_cnt = 0; stall_cnt = 0;
    run_instr(mk(1, 1, 0, 0, 4'd2, 32'h20, 32'h55), 1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("store rslt_o", rslt_o, 32'h20);
    chk("store regw_o", regw_o, 0);
    chk("store stall cycles", stall_cnt, 2);
    chk("store req cycles", req_cnt, 1);

    // Load with no ack: timeout
    req_cnt = 0;
    run_instr(mk(1, 0, 1, 1, 4'd9, 32'h300, 32'h0), 0, '0);
    @(negedge clk);
    chk("timeout req cycles", req_cnt, TIMEOUT);
    chk("timeout err", err_timeout, 1);
    chk("timeout regw_o", regw_o, 0);
    chk("timeout rslt_o", rslt_o, 0);
    run_instr(mk(1, 0, 0, 1, 4'd4, 32'h77, 32'h0), 0, '0);
    @(negedge clk);
    chk("post-timeout rslt_o", rslt_o, 32'h77);
    chk("err sticky", err_timeout, 1);

    // Ack on the cycle that would otherwise time out, then back-to-back loads
    run_instr(mk(1, 0, 1, 1, 4'd1, 32'h400, 32'h0), TIMEOUT, 32'hCAFE_0001);
    run_instr(mk(1, 0, 1, 1, 4'd2, 32'h404, 32'h0), 1, 32'hCAFE_0002);
    run_instr(mk(1, 0, 1, 1, 4'd3, 32'h408, 32'h0), 2, 32'hCAFE_0003);

    // Reset during WAIT cycle 2
    i = mk(1, 0, 1, 1, 4'd6, 32'h500, 32'h0);
    e = '0; e.stall = 1'b1; e.err = err_m;
    step(i, 1'b0, '0, e);
    e.req = 1'b1; e.addr = 32'h500;
    step(i, 1'b0, '0, e);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst mem_req", mem_req, 0);
    chk("midrst stall_M", stall_M, 0);
    chk("midrst mem_addr", mem_addr, 0);
    chk("midrst regw_o", regw_o, 0);
    chk("midrst err", err_timeout, 0);
    err_m = 1'b0;
    valid_M = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_instr(mk(1, 0, 0, 1, 4'd8, 32'h99, 32'h0), 0, '0);
    @(negedge clk);
    chk("after rst rslt_o", rslt_o, 32'h99);
    chk("after rst err", err_timeout, 0);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      i.valid  = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: begin i.memw = 1'b0; i.regmem = 1'b0; end
        1: begin i.memw = 1'b0; i.regmem = 1'b1; end
        2: begin i.memw = 1'b1; i.regmem = 1'b0; end
        default: begin i.memw = 1'b1; i.regmem = 1'b1; end
      endcase
      i.regw   = $urandom_range(0, 1);
      i.pcload = $urandom_range(0, 1);
      i.scr    = M'($urandom);
      i.alu    = $urandom;
      i.wd     = $urandom;
      if ($urandom_range(0, 5) == 0) lat = $urandom_range(0, TIMEOUT + 2);
      else                           lat = $urandom_range(1, 3);
      run_instr(i, lat, $urandom);
    end

    repeat (2) @(negedge clk);
    chk("expected queue drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the pipelined processor. It sits between the execute-memory pipeline register and the memory-writeback pipeline register.
- Non-memory instructions pass straight through to the writeback pipe.
- Loads and stores run a req/ack transaction with data memory through a small FSM. While a transaction is in flight, the block stalls upstream and drives bubbles downstream.
- A wait-cycle counter bounds each transaction and raises a sticky timeout error.

Parameters:
- N, 32, data/address width
- M, 4, register-index width
- TIMEOUT, 16, maximum WAIT cycles before abort (>=1); counter width $clog2(TIMEOUT+1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- valid_M  in  1  instruction present in memory stage
- memw_M  in  1  store instruction
- regmem_M  in  1  load instruction (writeback selects memory data)
- regw_M  in  1  register write enable
- pcload_M  in  1  PC-load flag
- regScr_M  in  M  destination register index
- ALUrslt_M  in  N  ALU result / memory address
- wdata_M  in  N  store data
- mem_req  out  1  memory request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  N  memory address
- mem_wdata  out  N  memory write data
- mem_rdata  in  N  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion
- stall_M  out  1  hold upstream stages and the current instruction
- pcload_o, regw_o, regmem_o  out  1 each  to mwpipe
- regScr_o  out  M  to mwpipe
- rslt_o  out  N  to mwpipe: load data for loads, ALUrslt_M otherwise
- err_timeout  out  1  sticky timeout flag

Behaviour:
- States: IDLE, WAIT, DONE. State register, rdata capture register, wait counter and err_timeout reset asynchronously on rst=0 to IDLE, 0, 0, 0.
- Reset values while rst=0: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stall_M=0, all *_o=0, err_timeout=0.
- mem_op = valid_M & (memw_M | regmem_M). If memw_M and regmem_M are both 1, the instruction is treated as a store.
- IDLE:
  - valid_M=0: all *_o=0 (bubble), stall_M=0.
  - Non-mem instruction: *_o = *_M combinationally, rslt_o=ALUrslt_M, stall_M=0. Output latency is 0 cycles; mwpipe provides the register.
  - mem_op=1: stall_M=1, outputs bubble, mem_req stays 0. Next state WAIT; counter cleared.
- WAIT:
  - mem_req=1 (Moore); mem_we=memw_M; mem_addr=ALUrslt_M; mem_wdata=wdata_M.
  - stall_M=1, outputs bubble.
  - Upstream holds all *_M stable while stall_M=1.
  - mem_ack=1: capture mem_rdata, clear counter, go to DONE.
  - Else counter += 1. When the counter reaches TIMEOUT-1 without ack: set err_timeout, capture 0, mark the transaction aborted, go to DONE.
  - mem_ack together with the timeout-reaching cycle: ack wins, no error.
- DONE:
  - mem_req=0, stall_M=0. Upstream advances at this edge.
  - *_o = *_M. rslt_o = captured rdata if regmem_M & ~memw_M, else ALUrslt_M.
  - If aborted: regw_o=0 and regmem_o=0, so no register write.
  - Next state IDLE unconditionally. A back-to-back mem op therefore re-enters WAIT via IDLE.
- mem_ack outside WAIT is ignored; no capture, no state change.
- mem_req rises exactly one cycle after stall_M rises. It is held continuously until the ack edge and never toggles mid-transaction.
- Minimum memory-op occupancy is 3 cycles (IDLE, WAIT, DONE) with zero-wait ack. Each extra wait cycle adds one.
- err_timeout is cleared only by reset.
- rst=0 mid-transaction drops mem_req and stall_M immediately (asynchronously) and discards the captured data.

Test Plan:
- Non-mem op (regw_M=1, regScr_M=3, ALUrslt_M=0x0000_00AA) -> same cycle regw_o=1, regScr_o=3, rslt_o=0xAA, stall_M=0, mem_req never 1.
- Load at addr 0x100, ack on 3rd WAIT cycle with mem_rdata=0xDEAD_BEEF -> stall_M=1 for 4 cycles, mem_req=1 for 3 cycles, mem_we=0, mem_addr=0x100; then DONE with regmem_o=1, rslt_o=0xDEADBEEF, bubbles before.
- Store addr 0x20, wdata 0x55, ack in first WAIT cycle -> mem_we=1, mem_wdata=0x55, stall 2 cycles, DONE rslt_o=0x20, regw_o=0.
- Load with no ack, TIMEOUT=16 -> mem_req high 16 cycles, then err_timeout=1 and stays 1, DONE with regw_o=0, rslt_o=0; next non-mem op passes normally.
- rst pulled low during WAIT cycle 2 -> mem_req, stall_M and *_o go 0 before the next edge; after release, state IDLE, err_timeout=0.
- mem_ack pulsed in IDLE and in DONE -> no state change, rslt_o unaffected. Back-to-back loads each show a separate IDLE-WAIT-DONE sequence.
